// File: rtl/sqrt_task_scheduler.sv
// sqrt_task_scheduler: round-robin dispatcher and in-order collector for a
// pool of N_UNITS formula units. Each triple goes to the next unit in turn.
// Results are released in acceptance order through a valid/ready port.
// Optional feature: define SQRT_SCHED_STALL_CNT_EN to add a saturating 32-bit
// stall_cnt output. It counts producer stall cycles (arg_vld && !arg_rdy).
module sqrt_task_scheduler #(
    parameter int N_UNITS = 4,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arg_vld,
    output logic                 arg_rdy,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic [W-1:0]         c,
    output logic                 res_vld,
    input  logic                 res_rdy,
    output logic [W-1:0]         res,
    output logic [N_UNITS-1:0]   u_arg_vld,
    output logic [W-1:0]         u_a,
    output logic [W-1:0]         u_b,
    output logic [W-1:0]         u_c,
    input  logic [N_UNITS-1:0]   u_res_vld,
    input  logic [N_UNITS*W-1:0] u_res
`ifdef SQRT_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slot_state_t;

    slot_state_t        slot_q [N_UNITS];
    slot_state_t        slot_d [N_UNITS];
    logic [W-1:0]       hold_q [N_UNITS];
    logic [W-1:0]       hold_d [N_UNITS];
    logic [PW-1:0]      dp_q;
    logic [PW-1:0]      dp_d;
    logic [PW-1:0]      cp_q;
    logic [PW-1:0]      cp_d;
    logic               accept;
    logic               pop;
    logic [N_UNITS-1:0] u_arg_vld_d;

    // Pointer increment that wraps at N_UNITS-1 so non-power-of-two pools work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(N_UNITS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake signals come only from registered slot state and pointers.
    always_comb begin
        arg_rdy = (slot_q[dp_q] == IDLE);
        accept  = arg_vld && arg_rdy;
        res_vld = (slot_q[cp_q] == DONE);
        res     = hold_q[cp_q];
        pop     = res_vld && res_rdy;
    end

    // Per-slot next state. A done pulse only counts while the slot is BUSY.
    always_comb begin
        dp_d        = dp_q;
        cp_d        = cp_q;
        u_arg_vld_d = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            slot_d[i] = slot_q[i];
            hold_d[i] = hold_q[i];
            case (slot_q[i])
                IDLE: begin
                    if (accept && (dp_q == PW'(i))) begin
                        slot_d[i]      = BUSY;
                        u_arg_vld_d[i] = 1'b1;
                    end
                end
                BUSY: begin
                    if (u_res_vld[i]) begin
                        slot_d[i] = DONE;
                        hold_d[i] = u_res[i*W +: W];
                    end
                end
                DONE: begin
                    if (pop && (cp_q == PW'(i))) begin
                        slot_d[i] = IDLE;
                    end
                end
                default: slot_d[i] = IDLE;
            endcase
        end
        if (accept) begin
            dp_d = next_ptr(dp_q);
        end
        if (pop) begin
            cp_d = next_ptr(cp_q);
        end
    end

    // Slot state, holding registers and ring pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_UNITS; i++) begin
                slot_q[i] <= IDLE;
                hold_q[i] <= '0;
            end
            dp_q <= '0;
            cp_q <= '0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                slot_q[i] <= slot_d[i];
                hold_q[i] <= hold_d[i];
            end
            dp_q <= dp_d;
            cp_q <= cp_d;
        end
    end

    // Start pulse and broadcast arguments. The arguments hold between accepts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            u_arg_vld <= '0;
            u_a       <= '0;
            u_b       <= '0;
            u_c       <= '0;
        end else begin
            u_arg_vld <= u_arg_vld_d;
            if (accept) begin
                u_a <= a;
                u_b <= b;
                u_c <= c;
            end
        end
    end

`ifdef SQRT_SCHED_STALL_CNT_EN
    // Saturating count of cycles in which the producer is held off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (arg_vld && !arg_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_task_scheduler.sv
// tb_sqrt_task_scheduler: stub units with configurable latency, a queue-based
// reference model of the scheduler's observable behaviour, directed scenarios
// and randomized traffic.
module tb_sqrt_task_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           arg_vld = 1'b0;
    logic           res_rdy = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic           arg_rdy;
    logic           res_vld;
    logic [W-1:0]   res;
    logic [N-1:0]   u_arg_vld;
    logic [W-1:0]   u_a;
    logic [W-1:0]   u_b;
    logic [W-1:0]   u_c;
    logic [N-1:0]   u_res_vld;
    logic [N*W-1:0] u_res;
`ifdef SQRT_SCHED_STALL_CNT_EN
    logic [31:0]    stall_cnt;
`endif

    sqrt_task_scheduler #(.N_UNITS(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg_rdy   (arg_rdy),
        .a         (a),
        .b         (b),
        .c         (c),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res       (res),
        .u_arg_vld (u_arg_vld),
        .u_a       (u_a),
        .u_b       (u_b),
        .u_c       (u_c),
        .u_res_vld (u_res_vld),
        .u_res     (u_res)
`ifdef SQRT_SCHED_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Stub units: result = a + 1, done pulse L cycles after the start pulse.
    int           lat  [N];
    int           scnt [N];
    logic [W-1:0] sres [N];
    logic [N-1:0] sbusy   = '0;
    logic [N-1:0] inj_vld = '0;
    logic [W-1:0] inj_val = '0;

    // Stub countdown, restarted by every start pulse.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (u_arg_vld[i]) begin
                sbusy[i] <= 1'b1;
                scnt[i]  <= lat[i] - 1;
                sres[i]  <= u_a + 32'd1;
            end else if (sbusy[i]) begin
                if (scnt[i] == 0) sbusy[i] <= 1'b0;
                else              scnt[i]  <= scnt[i] - 1;
            end
        end
    end

    // Stub outputs. inj_vld forces spurious pulses to exercise protocol violations.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            u_res_vld[i]     = (sbusy[i] && (scnt[i] == 0)) || inj_vld[i];
            u_res[i*W +: W]  = inj_vld[i] ? inj_val : sres[i];
        end
    end

    // Reference model: the in-flight entries in acceptance order. Each entry
    // carries its result and the cycle from which it is allowed to be shown.
    typedef struct {
        logic [W-1:0] val;
        int           ready;
    } ent_t;

    ent_t         q[$];
    int           cyc     = 0;
    int           acc_cnt = 0;
    logic [N-1:0] m_uvld  = '0;
    logic [W-1:0] m_a     = '0;
    logic [W-1:0] m_b     = '0;
    logic [W-1:0] m_c     = '0;
    logic [31:0]  m_stall = '0;
    int           total   = 0;
    int           bad     = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rr, input logic [W-1:0] aa,
                                 input logic [W-1:0] bb, input logic [W-1:0] cc);
        arg_vld = v;
        res_rdy = rr;
        a       = aa;
        b       = bb;
        c       = cc;
    endtask

    // One clock: compare against the model mid-cycle, then advance the model at the edge.
    task automatic stepCycle();
        logic e_rdy;
        logic e_vld;
        logic acc;
        logic pp;
        ent_t e;
        @(negedge clk);
        e_rdy = (q.size() < N);
        e_vld = (q.size() > 0) && (cyc >= q[0].ready);
        checkOutput("arg_rdy", 32'(arg_rdy), 32'(e_rdy));
        checkOutput("res_vld", 32'(res_vld), 32'(e_vld));
        if (e_vld) checkOutput("res", res, q[0].val);
        checkOutput("u_arg_vld", 32'(u_arg_vld), 32'(m_uvld));
        checkOutput("u_a", u_a, m_a);
        checkOutput("u_b", u_b, m_b);
        checkOutput("u_c", u_c, m_c);
`ifdef SQRT_SCHED_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, m_stall);
`endif
        acc = arg_vld && e_rdy;
        pp  = e_vld && res_rdy;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            acc_cnt = 0;
            m_uvld  = '0;
            m_a     = '0;
            m_b     = '0;
            m_c     = '0;
            m_stall = '0;
        end else begin
            if (arg_vld && !e_rdy && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            m_uvld = acc ? (N'(1) << (acc_cnt % N)) : '0;
            if (pp) void'(q.pop_front());
            if (acc) begin
                m_a     = a;
                m_b     = b;
                m_c     = c;
                e.val   = a + 32'd1;
                e.ready = cyc + lat[acc_cnt % N] + 2;
                q.push_back(e);
                acc_cnt++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        stepCycle();
        rst = 1'b1;
    endtask

    task automatic drain(input int maxc);
        applyStimulus(1'b0, 1'b1, '0, '0, '0);
        for (int k = 0; k < maxc && q.size() > 0; k++) stepCycle();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: %0d results left, 0 required", q.size());
        end
        repeat (3) stepCycle();
    endtask

    task automatic setLat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
        lat[3] = l3;
    endtask

    typedef struct {
        logic         vld;
        logic [W-1:0] arg;
        logic         e_rdy;
        logic [N-1:0] e_uvld;
        logic         e_rvld;
        logic [W-1:0] e_res;
    } vec_t;

    vec_t tv [14];
    int   pulses;

    initial begin
        // Single triple: start pulse in cycle 1, result 17 in cycle 12 only.
        for (int i = 0; i < 14; i++) tv[i] = '{1'b0, '0, 1'b1, '0, 1'b0, '0};
        tv[0].vld    = 1'b1;
        tv[0].arg    = 32'd16;
        tv[1].e_uvld = 4'b0001;
        tv[12].e_rvld = 1'b1;
        tv[12].e_res  = 32'd17;

        setLat(10, 10, 10, 10);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Table-driven single-triple latency check.
        doReset();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tv[i].vld, 1'b1, tv[i].arg, '0, '0);
            checkOutput("t1_arg_rdy", 32'(arg_rdy), 32'(tv[i].e_rdy));
            checkOutput("t1_u_arg_vld", 32'(u_arg_vld), 32'(tv[i].e_uvld));
            checkOutput("t1_res_vld", 32'(res_vld), 32'(tv[i].e_rvld));
            if (tv[i].e_rvld) checkOutput("t1_res", res, tv[i].e_res);
            stepCycle();
        end
        drain(40);

        // Full pool stall: four accepts, nine stalled cycles, fifth on unit 0.
        doReset();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(k < 14, 1'b1, 32'(200 + ((k < 4) ? k : 4)), 32'(k), 32'd7);
            checkOutput("t2_arg_rdy", 32'(arg_rdy), 32'((k < 4) || (k == 13) || (k == 14)));
`ifdef SQRT_SCHED_STALL_CNT_EN
            if (k == 13) checkOutput("t2_stall_cnt", stall_cnt, 32'd9);
`endif
            if (k == 14) checkOutput("t2_fifth_unit", 32'(u_arg_vld), 32'h1);
            stepCycle();
        end
        drain(60);

        // Out-of-order completion: unit 0 slow, results still leave 2,3,4,5.
        doReset();
        setLat(20, 5, 5, 5);
        for (int k = 0; k < 27; k++) begin
            applyStimulus(k < 4, 1'b1, 32'(k + 1), '0, '0);
            if (k == 4)  checkOutput("t3_full_rdy", 32'(arg_rdy), 32'd0);
            if (k == 15 || k == 21) checkOutput("t3_wait_vld", 32'(res_vld), 32'd0);
            if (k >= 22 && k <= 25) begin
                checkOutput("t3_order_vld", 32'(res_vld), 32'd1);
                checkOutput("t3_order_res", res, 32'(k - 20));
            end
            stepCycle();
        end
        drain(60);

        // Consumer backpressure with spurious unit pulses.
        doReset();
        setLat(10, 10, 10, 10);
        for (int k = 0; k < 36; k++) begin
            applyStimulus(k <= 31, k >= 30, 32'(300 + ((k < 4) ? k : 4)), '0, '0);
            inj_vld = (k == 1) ? 4'b0100 : (k == 20) ? 4'b0001 : 4'b0000;
            inj_val = 32'hDEAD;
            if (k >= 4 && k <= 30) checkOutput("t4_stall_rdy", 32'(arg_rdy), 32'd0);
            if (k == 31) checkOutput("t4_reopen_rdy", 32'(arg_rdy), 32'd1);
            if (k >= 12 && k <= 29) begin
                checkOutput("t4_hold_vld", 32'(res_vld), 32'd1);
                checkOutput("t4_hold_res", res, 32'd301);
            end
            if (k >= 30 && k <= 33) begin
                checkOutput("t4_burst_vld", 32'(res_vld), 32'd1);
                checkOutput("t4_burst_res", res, 32'(301 + k - 30));
            end
            stepCycle();
        end
        inj_vld = '0;
        drain(60);

        // Wrap: nine triples, the ninth start pulse lands on unit 0 again.
        doReset();
        pulses = 0;
        for (int k = 0; k < 80 && pulses < 9; k++) begin
            applyStimulus(acc_cnt < 9, 1'b1, 32'(500 + acc_cnt), 32'(acc_cnt), '0);
            if (u_arg_vld != '0) begin
                pulses++;
                if (pulses == 9) checkOutput("t5_ninth_unit", 32'(u_arg_vld), 32'h1);
            end
            stepCycle();
        end
        if (pulses < 9) begin
            total++;
            bad++;
            $display("[TB] FAIL t5_timeout: %0d start pulses, 9 required", pulses);
        end
        drain(80);

        // Mid-operation reset with three triples in flight.
        doReset();
        for (int k = 0; k < 32; k++) begin
            applyStimulus(k < 3 || k == 31, 1'b1, 32'(600 + k), 32'd3, 32'd4);
            rst = (k != 5);
            if (k == 6) begin
                checkOutput("t6_rdy", 32'(arg_rdy), 32'd1);
                checkOutput("t6_res_vld", 32'(res_vld), 32'd0);
                checkOutput("t6_res", res, 32'd0);
                checkOutput("t6_u_arg_vld", 32'(u_arg_vld), 32'd0);
                checkOutput("t6_u_a", u_a, 32'd0);
            end
            if (k > 6) checkOutput("t6_late_vld", 32'(res_vld), 32'd0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b1, '0, '0, '0);
        checkOutput("t6_restart_unit", 32'(u_arg_vld), 32'h1);
        drain(40);

        // Randomized traffic against the model, two latency sets.
        for (int r = 0; r < 2; r++) begin
            doReset();
            for (int i = 0; i < N; i++) lat[i] = int'($urandom_range(1, 12));
            for (int k = 0; k < 800; k++) begin
                applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                              $urandom, $urandom, $urandom);
                stepCycle();
            end
            drain(200);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
